ahb_sram_sub: RTL and testbench

AHB 5 subordinate wrapping a word-addressed SRAM array with programmable wait states. Produces rData, readyOut and resp for one mux input port. Consumes the decoder select and the broadcast manager address/control/write-data signals. Provides the memory endpoint the interconnect tests against, including OKAY, wait-state and ERROR responses.

---
 rtl/ahb_sram_sub.sv | 147 ++++++++++++++
 tb/tb_ahb_sram_sub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_sub.sv
// AHB subordinate fronting a word-addressed SRAM with a fixed number of data-phase wait states.
// Out-of-range, oversized or misaligned transfers get a two-cycle ERROR response and never touch the array.
module ahb_sram_sub #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 256,
  parameter int WaitStates = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write,
  input  logic [1:0]           trans,
  input  logic [2:0]           size,
  input  logic [DataWidth-1:0] wData,
  input  logic                 readyIn,
  output logic [DataWidth-1:0] rData,
  output logic                 readyOut,
  output logic                 resp
);

  localparam int ByteW = DataWidth / 8;
  localparam int OffW  = $clog2(ByteW);
  localparam int OffWc = (OffW > 0) ? OffW : 1;
  localparam int IdxW  = $clog2(Depth);
  localparam logic [AddrWidth:0] Limit    = (AddrWidth+1)'(Depth * ByteW);
  localparam logic [OffWc-1:0]   OffMask  = OffWc'(ByteW - 1);
  localparam logic [3:0]         WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [OffWc-1:0]     off_q, off_d;
  logic [2:0]           size_q, size_d;
  logic                 write_q, write_d;
  logic                 readyOut_q, readyOut_d;
  logic                 resp_q, resp_d;
  logic                 accept;
  logic [ByteW-1:0]     lane_en;

  logic [DataWidth-1:0] mem [Depth];

  function automatic logic xfer_err(input logic [AddrWidth-1:0] a, input logic [2:0] sz);
    logic e;
    e = ({1'b0, a} >= Limit) || (int'(sz) > OffW);
    for (int i = 0; i < 8; i++) begin
      if (i < AddrWidth && i < int'(sz) && a[i]) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [ByteW-1:0] lane_mask(input logic [2:0] sz, input logic [OffWc-1:0] off);
    logic [ByteW-1:0] m;
    int lo;
    int n;
    lo = int'(off);
    n  = 1 << sz;
    for (int b = 0; b < ByteW; b++) begin
      m[b] = (b >= lo) && (b < lo + n);
    end
    return m;
  endfunction

  // Address phase: only sampled when this block is presenting readyOut=1
  assign accept = (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2) &&
                  sel && readyIn && (trans == 2'b10 || trans == 2'b11);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d   = addr[OffW +: IdxW];
      off_d   = addr[OffWc-1:0] & OffMask;
      size_d  = size;
      write_d = write;
      if (xfer_err(addr, size)) begin
        state_d = S_ERR1;
      end else if (WaitStates > 0) begin
        state_d = S_WAIT;
        cnt_d   = WaitLoad;
      end else begin
        state_d = S_DATA;
      end
    end
    readyOut_d = !(state_d == S_WAIT || state_d == S_ERR1);
    resp_d     = (state_d == S_ERR1 || state_d == S_ERR2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      off_q      <= '0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
      readyOut_q <= 1'b1;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      size_q     <= size_d;
      write_q    <= write_d;
      readyOut_q <= readyOut_d;
      resp_q     <= resp_d;
    end
  end

  assign lane_en = lane_mask(size_q, off_q);

  // Write commits on the edge that ends DATA; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_DATA && write_q) begin
      for (int b = 0; b < ByteW; b++) begin
        if (lane_en[b]) mem[idx_q][b*8 +: 8] <= wData[b*8 +: 8];
      end
    end
  end

  assign rData    = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;
  assign readyOut = readyOut_q;
  assign resp     = resp_q;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Directed bench for ahb_sram_sub: one zero-wait and one two-wait instance share the bus signals,
// each enabled by its own select.
module tb_ahb_sram_sub;

  logic        clk;
  logic        rst;
  logic        sel0, sel2;
  logic [31:0] addr;
  logic        wr;
  logic [1:0]  trans;
  logic [2:0]  size;
  logic [31:0] wData;
  wire  logic  readyIn;
  logic [31:0] rd0, rd2;
  logic        ro0, ro2, rs0, rs2;

  int n_tests = 0;
  int n_fail  = 0;

  assign readyIn = ro0 & ro2;

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(0)) u_ws0 (
    .clk(clk), .rst(rst), .sel(sel0), .addr(addr), .write(wr), .trans(trans), .size(size),
    .wData(wData), .readyIn(readyIn), .rData(rd0), .readyOut(ro0), .resp(rs0)
  );

  ahb_sram_sub #(.DataWidth(32), .AddrWidth(32), .Depth(256), .WaitStates(2)) u_ws2 (
    .clk(clk), .rst(rst), .sel(sel2), .addr(addr), .write(wr), .trans(trans), .size(size),
    .wData(wData), .readyIn(readyIn), .rData(rd2), .readyOut(ro2), .resp(rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    sel0 = 1'b0; sel2 = 1'b0; trans = 2'd0; wr = 1'b0;
  endtask

  task automatic addr_ph(input logic s0, input logic s2, input logic [1:0] t, input logic w,
                         input logic [31:0] a, input logic [2:0] sz);
    sel0 = s0; sel2 = s2; trans = t; wr = w; addr = a; size = sz;
  endtask

  task automatic wr_ws0(input logic [31:0] a, input logic [31:0] d);
    addr_ph(1'b1, 1'b0, 2'd2, 1'b1, a, 3'd2);
    step();
    wData = d;
    bus_idle();
    step();
  endtask

  task automatic wr_ws2(input logic [31:0] a, input logic [31:0] d);
    addr_ph(1'b0, 1'b1, 2'd2, 1'b1, a, 3'd2);
    wData = d;
    step();
    bus_idle();
    step();
    step();
    step();
  endtask

  task automatic rd_ws0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, a, 3'd2);
    step();
    chk({tag, "_ready"}, {31'd0, ro0}, 32'd1);
    chk(tag, rd0, exp);
    bus_idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    wData = 32'd0;
    addr = 32'd0;
    size = 3'd0;
    bus_idle();
    step();
    step();
    // Reset state of both instances
    chk("rst_ready0", {31'd0, ro0}, 32'd1);
    chk("rst_resp0",  {31'd0, rs0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ready2", {31'd0, ro2}, 32'd1);
    chk("rst_resp2",  {31'd0, rs2}, 32'd0);
    rst = 1'b0;
    step();

    // Zero-wait write then pipelined read of 0x10
    addr_ph(1'b1, 1'b0, 2'd2, 1'b1, 32'h10, 3'd2);
    step();
    chk("w10_ready", {31'd0, ro0}, 32'd1);
    chk("w10_resp",  {31'd0, rs0}, 32'd0);
    wData = 32'hDEADBEEF;
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 3'd2);
    step();
    chk("r10_ready", {31'd0, ro0}, 32'd1);
    chk("r10_resp",  {31'd0, rs0}, 32'd0);
    chk("r10_data",  rd0, 32'hDEADBEEF);
    bus_idle();
    step();
    chk("idle_rdata", rd0, 32'd0);

    // Preloads
    wr_ws0(32'h0,   32'hA0A0A0A0);
    wr_ws0(32'h4,   32'hA1A1A1A1);
    wr_ws0(32'h8,   32'hA2A2A2A2);
    wr_ws0(32'h3FC, 32'hCAFEF00D);
    wr_ws0(32'h20,  32'h11223344);

    // Out-of-range write must error and not alias onto word 0
    addr_ph(1'b1, 1'b0, 2'd2, 1'b1, 32'h400, 3'd2);
    wData = 32'hBAD0BAD0;
    step();
    chk("e400_c1_ready", {31'd0, ro0}, 32'd0);
    chk("e400_c1_resp",  {31'd0, rs0}, 32'd1);
    step();
    chk("e400_c2_ready", {31'd0, ro0}, 32'd1);
    chk("e400_c2_resp",  {31'd0, rs0}, 32'd1);
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 3'd2);
    step();
    chk("r3fc_resp", {31'd0, rs0}, 32'd0);
    chk("r3fc_data", rd0, 32'hCAFEF00D);
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 3'd2);
    step();
    chk("r0_after_err", rd0, 32'hA0A0A0A0);
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 3'd2);
    step();
    chk("r400_c1_ready", {31'd0, ro0}, 32'd0);
    chk("r400_c1_resp",  {31'd0, rs0}, 32'd1);
    chk("r400_c1_rdata", rd0, 32'd0);
    bus_idle();
    step();
    chk("r400_c2_resp", {31'd0, rs0}, 32'd1);
    step();
    chk("post_err_resp", {31'd0, rs0}, 32'd0);

    // Byte write into lane 2 of word 0x20
    addr_ph(1'b1, 1'b0, 2'd2, 1'b1, 32'h22, 3'd0);
    step();
    wData = 32'h00AA0000;
    bus_idle();
    step();
    rd_ws0("byte_wr", 32'h20, 32'h11AA3344);

    // Misaligned halfword write errors and leaves the word alone
    addr_ph(1'b1, 1'b0, 2'd2, 1'b1, 32'h21, 3'd1);
    wData = 32'hFFFFFFFF;
    step();
    chk("hw21_resp", {31'd0, rs0}, 32'd1);
    chk("hw21_ready", {31'd0, ro0}, 32'd0);
    bus_idle();
    step();
    step();
    rd_ws0("hw21_unchanged", 32'h20, 32'h11AA3344);

    // Oversized transfer errors
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 3'd3);
    step();
    chk("size3_resp", {31'd0, rs0}, 32'd1);
    bus_idle();
    step();
    step();

    // Back-to-back NONSEQ, SEQ, SEQ reads with no bubbles
    addr_ph(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 3'd2);
    step();
    chk("b2b0_ready", {31'd0, ro0}, 32'd1);
    chk("b2b0_data", rd0, 32'hA0A0A0A0);
    addr_ph(1'b1, 1'b0, 2'd3, 1'b0, 32'h4, 3'd2);
    step();
    chk("b2b1_ready", {31'd0, ro0}, 32'd1);
    chk("b2b1_data", rd0, 32'hA1A1A1A1);
    addr_ph(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 3'd2);
    step();
    chk("b2b2_ready", {31'd0, ro0}, 32'd1);
    chk("b2b2_data", rd0, 32'hA2A2A2A2);
    bus_idle();
    step();

    // Two wait states on a read of 0x04
    wr_ws2(32'h4, 32'h5A5A1234);
    addr_ph(1'b0, 1'b1, 2'd2, 1'b0, 32'h4, 3'd2);
    step();
    chk("ws2_c1_ready", {31'd0, ro2}, 32'd0);
    chk("ws2_c1_resp",  {31'd0, rs2}, 32'd0);
    chk("ws2_c1_rdata", rd2, 32'd0);
    bus_idle();
    step();
    chk("ws2_c2_ready", {31'd0, ro2}, 32'd0);
    chk("ws2_c2_resp",  {31'd0, rs2}, 32'd0);
    step();
    chk("ws2_c3_ready", {31'd0, ro2}, 32'd1);
    chk("ws2_c3_resp",  {31'd0, rs2}, 32'd0);
    chk("ws2_c3_data",  rd2, 32'h5A5A1234);
    step();

    // Reset in the middle of a waited write drops the write
    wr_ws2(32'h30, 32'h55667788);
    addr_ph(1'b0, 1'b1, 2'd2, 1'b1, 32'h30, 3'd2);
    wData = 32'h99999999;
    step();
    chk("rstw_wait_ready", {31'd0, ro2}, 32'd0);
    rst = 1'b1;
    step();
    chk("rstw_ready", {31'd0, ro2}, 32'd1);
    chk("rstw_resp",  {31'd0, rs2}, 32'd0);
    chk("rstw_rdata", rd2, 32'd0);
    rst = 1'b0;
    bus_idle();
    step();
    step();
    addr_ph(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 3'd2);
    step();
    bus_idle();
    step();
    step();
    chk("rstw_keep_ready", {31'd0, ro2}, 32'd1);
    chk("rstw_keep_data", rd2, 32'h55667788);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
